// File: rtl/core_mul_pkg.sv
// Shared encodings for the iterative multiplier: M-extension multiply controls
// and the sequencing FSM states.
package core_mul_pkg;

    localparam logic [1:0] CTRL_MUL    = 2'b00;
    localparam logic [1:0] CTRL_MULH   = 2'b01;
    localparam logic [1:0] CTRL_MULHSU = 2'b10;
    localparam logic [1:0] CTRL_MULHU  = 2'b11;
    localparam logic [1:0] CTRL_MULW   = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/core_mul_step.sv
// One shift-add step: adds multiplicand * slice (BPC bits) into the accumulator.
module core_mul_step #(
    parameter int XLEN = 64,
    parameter int BPC  = 2
) (
    input  logic [2*XLEN-1:0] multiplicand,
    input  logic [BPC-1:0]    slice,
    input  logic [2*XLEN-1:0] acc,
    output logic [2*XLEN-1:0] acc_next
);

    logic [2*XLEN-1:0] sum;

    always_comb begin
        sum = acc;
        for (int i = 0; i < BPC; i++) begin
            if (slice[i]) begin
                sum = sum + (multiplicand << i);
            end
        end
    end

    assign acc_next = sum;

endmodule

// File: rtl/core_mul_iter.sv
// Iterative unsigned-magnitude multiplier: sign/magnitude front end, shift-add
// datapath sequenced by a small FSM, registered valid/ready result port.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | shift-add iterations in progress
// DONE  | result held until downstream accepts it
module core_mul_iter
    import core_mul_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int BPC  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mul_valid,
    output logic              o_mul_ready,
    input  logic [XLEN-1:0]   i_mul_srcA,
    input  logic [XLEN-1:0]   i_mul_srcB,
    input  logic [1:0]        i_mul_control,
    input  logic              i_mul_isword,
    input  logic              i_mul_flush,
    output logic              o_mul_valid,
    input  logic              i_mul_ready,
    output logic [2*XLEN-1:0] o_mul_product,
    output logic              o_mul_srcA_Dsign,
    output logic              o_mul_srcB_Dsign,
    output logic              o_mul_srcA_Wsign,
    output logic              o_mul_srcB_Wsign,
    output logic [1:0]        o_mul_control,
    output logic              o_mul_isword
);

    localparam int HALF  = XLEN / 2;
    localparam int CNT_W = $clog2(XLEN / BPC + 1);
    localparam logic [CNT_W-1:0] LAST_DW = CNT_W'(XLEN / BPC - 1);
    localparam logic [CNT_W-1:0] LAST_W  = CNT_W'(HALF / BPC - 1);

    mul_state_e        state;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [CNT_W-1:0]  cnt;

    logic            signed_a, signed_b, word_signed;
    logic            dsign_a, dsign_b, wsign_a, wsign_b;
    logic [HALF-1:0] lo_a, lo_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            accept;

    always_comb begin
        signed_a    = (i_mul_control != CTRL_MULHU);
        signed_b    = (i_mul_control == CTRL_MUL) || (i_mul_control == CTRL_MULH);
        word_signed = i_mul_isword && (i_mul_control == CTRL_MULW);
        dsign_a     = !i_mul_isword && signed_a && i_mul_srcA[XLEN-1];
        dsign_b     = !i_mul_isword && signed_b && i_mul_srcB[XLEN-1];
        wsign_a     = word_signed && i_mul_srcA[HALF-1];
        wsign_b     = word_signed && i_mul_srcB[HALF-1];
        lo_a        = i_mul_srcA[HALF-1:0];
        lo_b        = i_mul_srcB[HALF-1:0];
        // Negating the most-negative value yields 2^(W-1), which is the correct magnitude.
        if (i_mul_isword) begin
            mag_a = {{HALF{1'b0}}, (wsign_a ? -lo_a : lo_a)};
            mag_b = {{HALF{1'b0}}, (wsign_b ? -lo_b : lo_b)};
        end else begin
            mag_a = dsign_a ? -i_mul_srcA : i_mul_srcA;
            mag_b = dsign_b ? -i_mul_srcB : i_mul_srcB;
        end
    end

    assign o_mul_ready = (state == IDLE);
    assign accept      = i_mul_valid && (state == IDLE) && !i_mul_flush;

    core_mul_step #(
        .XLEN(XLEN),
        .BPC (BPC)
    ) u_step (
        .multiplicand(mcand),
        .slice       (mplier[BPC-1:0]),
        .acc         (acc),
        .acc_next    (acc_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            mcand            <= '0;
            mplier           <= '0;
            acc              <= '0;
            cnt              <= '0;
            o_mul_valid      <= 1'b0;
            o_mul_product    <= '0;
            o_mul_srcA_Dsign <= 1'b0;
            o_mul_srcB_Dsign <= 1'b0;
            o_mul_srcA_Wsign <= 1'b0;
            o_mul_srcB_Wsign <= 1'b0;
            o_mul_control    <= 2'b00;
            o_mul_isword     <= 1'b0;
        end else if (i_mul_flush) begin
            state       <= IDLE;
            o_mul_valid <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_mul_srcA_Dsign <= dsign_a;
                        o_mul_srcB_Dsign <= dsign_b;
                        o_mul_srcA_Wsign <= wsign_a;
                        o_mul_srcB_Wsign <= wsign_b;
                        o_mul_control    <= i_mul_control;
                        o_mul_isword     <= i_mul_isword;
                        acc              <= '0;
                        mcand            <= {{XLEN{1'b0}}, mag_a};
                        mplier           <= mag_b;
                        cnt              <= i_mul_isword ? LAST_W : LAST_DW;
                        if ((mag_a == '0) || (mag_b == '0)) begin
                            o_mul_product <= '0;
                            o_mul_valid   <= 1'b1;
                            state         <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << BPC;
                    mplier <= mplier >> BPC;
                    if (cnt == '0) begin
                        o_mul_product <= acc_next;
                        o_mul_valid   <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (i_mul_ready) begin
                        o_mul_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
